// File: rtl/tff_count_ctrl.sv
// tff_count_ctrl: start/stop/load sequencer driving a WIDTH-bit toggle bank as a modulo-M up/down counter
module tff_count_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             one_shot,
  input  logic [WIDTH-1:0] modulus,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] t_vec,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  localparam logic [WIDTH-1:0] one = 1;
  state_t state, state_next;
  logic [WIDTH:0] m_full, m1;
  logic [WIDTH-1:0] top, lv, q_next, run_next;
  logic term;
  // modulus 0 means 2^WIDTH, so M-1 needs one extra bit before truncation
  always_comb begin
    m_full = {modulus == '0, modulus};
    m1 = m_full - {{WIDTH{1'b0}}, 1'b1};
    top = m1[WIDTH-1:0];
    lv = ({1'b0, load_val} > m1) ? '0 : load_val;
    term = dir ? ({1'b0, q} >= m1) : (q == '0);
    run_next = stop ? q :
               term ? (one_shot ? q : (dir ? '0 : top)) :
               dir ? q + one :
               ({1'b0, q} > m1) ? top : q - one;
    tc = (state == RUN) && !stop && term;
    case (state)
      IDLE, PAUSE: begin
        state_next = stop ? (state == PAUSE ? IDLE : state) : start ? RUN : state;
        q_next = (!stop && !start && load) ? lv : q;
      end
      RUN: begin
        state_next = stop ? PAUSE : (term && one_shot) ? DONE : RUN;
        q_next = run_next;
      end
      default: begin
        state_next = stop ? IDLE : start ? RUN : DONE;
        q_next = stop ? q : start ? (dir ? '0 : top) : load ? lv : q;
      end
    endcase
    t_vec = q ^ q_next;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      q <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_next;
      q <= q ^ t_vec;
      busy <= (state_next == RUN) || (state_next == PAUSE);
      done <= state_next == DONE;
    end
  end
endmodule

// File: tb/tb_tff_count_ctrl.sv
// tb_tff_count_ctrl: vector table with scoreboard plus hand-written async reset sequence
module tb_tff_count_ctrl;
  logic clk = 0, reset = 0, start = 0, stop = 0, dir = 0, one_shot = 0, load = 0;
  logic [3:0] modulus = 0, load_val = 0;
  logic [3:0] t_vec, q;
  logic tc, busy, done;
  int ncmp = 0, nerr = 0;

  tff_count_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .dir(dir),
    .one_shot(one_shot), .modulus(modulus), .load(load), .load_val(load_val),
    .t_vec(t_vec), .q(q), .tc(tc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic st, sp, d, os;
    logic [3:0] mod;
    logic ld;
    logic [3:0] lv;
    logic [3:0] q, t;
    logic tc, b, dn;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic void add(logic st, logic sp, logic d, logic os, logic [3:0] mod,
                              logic ld, logic [3:0] lv, logic [3:0] eq, logic [3:0] et,
                              logic etc, logic eb, logic edn);
    vec_t v;
    v.st = st; v.sp = sp; v.d = d; v.os = os; v.mod = mod; v.ld = ld; v.lv = lv;
    v.q = eq; v.t = et; v.tc = etc; v.b = eb; v.dn = edn;
    tbl.push_back(v);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    vec_t e;
    logic [3:0] nq;
    // up count modulo 10
    add(1,0,1,0,10,0,0, 0,4'b0000,0,0,0);
    for (int i = 0; i < 10; i++) begin
      nq = (i == 9) ? 4'd0 : 4'(i + 1);
      add(0,0,1,0,10,0,0, 4'(i), 4'(i) ^ nq, i == 9, 1, 0);
    end
    add(0,0,1,0,10,0,0, 0,4'b0001,0,1,0);
    add(0,1,1,0,10,0,0, 1,4'b0000,0,1,0);
    add(0,1,1,0,10,0,0, 1,4'b0000,0,1,0);
    // one-shot down modulo 5 from 3
    add(0,0,0,1,5,1,3, 1,4'b0010,0,0,0);
    add(1,0,0,1,5,0,0, 3,4'b0000,0,0,0);
    add(0,0,0,1,5,0,0, 3,4'b0001,0,1,0);
    add(0,0,0,1,5,0,0, 2,4'b0011,0,1,0);
    add(0,0,0,1,5,0,0, 1,4'b0001,0,1,0);
    add(0,0,0,1,5,0,0, 0,4'b0000,1,1,0);
    add(0,0,0,1,5,0,0, 0,4'b0000,0,0,1);
    add(1,0,0,1,5,0,0, 0,4'b0100,0,0,1);
    add(0,1,0,1,5,0,0, 4,4'b0000,0,1,0);
    add(0,1,0,1,5,0,0, 4,4'b0000,0,1,0);
    // pause / resume / load ignored in RUN / abort / start+stop in IDLE
    add(0,0,1,0,10,1,5, 4,4'b0001,0,0,0);
    add(1,0,1,0,10,0,0, 5,4'b0000,0,0,0);
    add(0,1,1,0,10,0,0, 5,4'b0000,0,1,0);
    add(0,0,1,0,10,0,0, 5,4'b0000,0,1,0);
    add(0,0,1,0,10,0,0, 5,4'b0000,0,1,0);
    add(0,0,1,0,10,0,0, 5,4'b0000,0,1,0);
    add(1,0,1,0,10,0,0, 5,4'b0000,0,1,0);
    add(0,0,1,0,10,0,0, 5,4'b0011,0,1,0);
    add(0,0,1,0,10,1,2, 6,4'b0001,0,1,0);
    add(0,1,1,0,10,0,0, 7,4'b0000,0,1,0);
    add(0,1,1,0,10,0,0, 7,4'b0000,0,1,0);
    add(1,1,1,0,10,0,0, 7,4'b0000,0,0,0);
    add(0,0,1,0,10,0,0, 7,4'b0000,0,0,0);
    // modulus 0 wrap from 14
    add(0,0,1,0,0,1,14, 7,4'b1001,0,0,0);
    add(1,0,1,0,0,0,0, 14,4'b0000,0,0,0);
    add(0,0,1,0,0,0,0, 14,4'b0001,0,1,0);
    add(0,0,1,0,0,0,0, 15,4'b1111,1,1,0);
    add(0,0,1,0,0,0,0, 0,4'b0001,0,1,0);
    add(0,1,1,0,0,0,0, 1,4'b0000,0,1,0);
    add(0,1,1,0,0,0,0, 1,4'b0000,0,1,0);
    // out-of-range load clamps to 0
    add(0,0,1,0,10,1,12, 1,4'b0001,0,0,0);
    add(0,0,1,0,10,0,0, 0,4'b0000,0,0,0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst q", q, 0);
    chk("rst t_vec", t_vec, 0);
    chk("rst tc", tc, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    @(posedge clk); #1 reset = 1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      start = tbl[i].st; stop = tbl[i].sp; dir = tbl[i].d; one_shot = tbl[i].os;
      modulus = tbl[i].mod; load = tbl[i].ld; load_val = tbl[i].lv;
      sb.push_back(tbl[i]);
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("r%0d q", i), q, e.q);
      chk($sformatf("r%0d t_vec", i), t_vec, e.t);
      chk($sformatf("r%0d tc", i), tc, e.tc);
      chk($sformatf("r%0d busy", i), busy, e.b);
      chk($sformatf("r%0d done", i), done, e.dn);
    end

    // async reset mid-count at q=6
    @(posedge clk); #1 start = 1; stop = 0; load = 0; dir = 1; one_shot = 0; modulus = 10;
    @(posedge clk); #1 start = 0;
    repeat (6) @(posedge clk);
    #1 chk("pre_reset q", q, 6);
    #1 reset = 0;
    #1 chk("async q", q, 0);
    chk("async busy", busy, 0);
    chk("async t_vec", t_vec, 0);
    chk("async tc", tc, 0);
    @(posedge clk); #1 reset = 1; start = 1;
    @(posedge clk); #1 start = 0;
    chk("restart q", q, 0);
    chk("restart busy", busy, 1);
    @(posedge clk); #1 chk("restart step", q, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
